// File: rtl/ldl_rr_v2_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// The arbiter takes the slave side; the requester/downstream side takes master.
interface ldl_rr_v2_if #(
    parameter int BIN_WIDTH    = 3,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int REQ_WIDTH = 1 << BIN_WIDTH;

    logic [REQ_WIDTH-1:0]              req;
    logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight;
    logic                              lock;
    logic                              ready;
    logic                              valid;
    logic [REQ_WIDTH-1:0]              hot;
    logic [BIN_WIDTH-1:0]              bin;

    modport master (
        output req, weight, lock, ready,
        input  valid, hot, bin
    );

    modport slave (
        input  req, weight, lock, ready,
        output valid, hot, bin
    );
endinterface

// File: rtl/ldl_rr_v2.sv
// Weighted round-robin arbiter: grantee keeps the slot for up to weight beats, lock holds it.
// Latency: request to grant 1 clk, back-to-back grants one beat per clk with no bubble.
// Backpressure: ready=0 freezes grant, index and credits; request changes are ignored until ready.
module ldl_rr_v2 #(
    parameter int BIN_WIDTH    = 3,
    parameter int REQ_WIDTH    = 1 << BIN_WIDTH,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    ldl_rr_v2_if.slave  s
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_q, state_nxt;
    logic [BIN_WIDTH-1:0]    bin_q, bin_nxt;
    logic [BIN_WIDTH-1:0]    ptr_q, ptr_nxt;
    logic [REQ_WIDTH-1:0]    hot_q, hot_nxt;
    logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_nxt;

    logic                    any_req;
    logic                    own_req;
    logic [BIN_WIDTH-1:0]    pick_idle;
    logic [BIN_WIDTH-1:0]    pick_rot;

    // First set bit of v strictly after 'from', wrapping; k=REQ_WIDTH wraps back onto 'from'
    // so a sole requester can be re-granted.
    function automatic logic [BIN_WIDTH-1:0] sel(
        input logic [REQ_WIDTH-1:0] v,
        input logic [BIN_WIDTH-1:0] from
    );
        logic [BIN_WIDTH-1:0] idx;
        logic                 found;
        sel   = from;
        found = 1'b0;
        for (int k = 1; k <= REQ_WIDTH; k++) begin
            idx = from + BIN_WIDTH'(k);
            if (!found && v[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [WEIGHT_WIDTH-1:0] weff(
        input logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] w,
        input logic [BIN_WIDTH-1:0]              i
    );
        logic [WEIGHT_WIDTH-1:0] f;
        f = w[int'(i)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        return (f == '0) ? WEIGHT_WIDTH'(1) : f;
    endfunction

    assign any_req   = |s.req;
    assign own_req   = s.req[bin_q];
    assign pick_idle = sel(s.req, ptr_q);
    // On rotation the pointer moves to the finishing grantee before the search.
    assign pick_rot  = sel(s.req, bin_q);

    always_comb begin
        state_nxt = state_q;
        bin_nxt   = bin_q;
        ptr_nxt   = ptr_q;
        hot_nxt   = hot_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    bin_nxt   = pick_idle;
                    hot_nxt   = REQ_WIDTH'(1) << pick_idle;
                    cnt_nxt   = weff(s.weight, pick_idle);
                end
            end
            GRANT: begin
                if (s.ready) begin
                    if (s.lock && own_req) begin
                        cnt_nxt = cnt_q;
                    end else if ((cnt_q > WEIGHT_WIDTH'(1)) && own_req) begin
                        cnt_nxt = cnt_q - WEIGHT_WIDTH'(1);
                    end else begin
                        ptr_nxt = bin_q;
                        if (any_req) begin
                            bin_nxt = pick_rot;
                            hot_nxt = REQ_WIDTH'(1) << pick_rot;
                            cnt_nxt = weff(s.weight, pick_rot);
                        end else begin
                            state_nxt = IDLE;
                            hot_nxt   = '0;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            ptr_q   <= BIN_WIDTH'(REQ_WIDTH - 1);
            hot_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            bin_q   <= bin_nxt;
            ptr_q   <= ptr_nxt;
            hot_q   <= hot_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign s.valid = (state_q == GRANT);
    assign s.hot   = hot_q;
    assign s.bin   = bin_q;

    a_hot_match: assert property (@(posedge clk) disable iff (!rst_n)
        s.valid |-> (s.hot == (REQ_WIDTH'(1) << s.bin)));
    a_hot_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !s.valid |-> (s.hot == '0));
    a_cnt_live: assert property (@(posedge clk) disable iff (!rst_n)
        s.valid |-> (cnt_q != '0));

endmodule

// File: tb/tb_ldl_rr_v2.sv
// Bench for ldl_rr_v2: directed scenarios then random traffic, scored against a reference model.
module tb_ldl_rr_v2;
    localparam int N = 8;

    typedef struct packed {
        logic       v;
        logic [7:0] h;
        logic [2:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ldl_rr_v2_if #(.BIN_WIDTH(3), .WEIGHT_WIDTH(4)) bus ();

    ldl_rr_v2 #(.BIN_WIDTH(3), .WEIGHT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus.slave)
    );

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: owner index, credits left, last served index.
    int m_valid = 0;
    int m_bin   = 0;
    int m_last  = N - 1;
    int m_cred  = 0;

    function automatic int pick(input logic [7:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic int weff(input logic [31:0] w, input int i);
        int f;
        f = int'((w >> (i * 4)) & 32'hf);
        return (f == 0) ? 1 : f;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_valid = 0; m_bin = 0; m_last = N - 1; m_cred = 0;
        end else if (m_valid == 0) begin
            if (bus.req != 8'h00) begin
                m_bin   = pick(bus.req, m_last);
                m_valid = 1;
                m_cred  = weff(bus.weight, m_bin);
            end
        end else if (bus.ready) begin
            if (bus.lock && bus.req[m_bin]) begin
                m_cred = m_cred;
            end else if (m_cred > 1 && bus.req[m_bin]) begin
                m_cred = m_cred - 1;
            end else begin
                m_last = m_bin;
                if (bus.req != 8'h00) begin
                    m_bin  = pick(bus.req, m_last);
                    m_cred = weff(bus.weight, m_bin);
                end else begin
                    m_valid = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic r_n, input logic [7:0] r, input logic [31:0] w,
                       input logic lk, input logic rd);
        exp_t e;
        @(negedge clk);
        rst_n      = r_n;
        bus.req    = r;
        bus.weight = w;
        bus.lock   = lk;
        bus.ready  = rd;
        model_step();
        e.v = (m_valid != 0);
        e.b = 3'(m_bin);
        e.h = (m_valid != 0) ? (8'h01 << m_bin) : 8'h00;
        exp_q.push_back(e);
    endtask

    // Monitor: each post-edge output set is matched to the prediction for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (bus.valid !== e.v || bus.hot !== e.h || bus.bin !== e.b) begin
                    miscompares++;
                    $display("FAIL grant[%0d] got valid=%0b hot=%h bin=%0d want valid=%0b hot=%h bin=%0d",
                             vectors, bus.valid, bus.hot, bus.bin, e.v, e.h, e.b);
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  r;
        int          budget;
        bus.req = 8'h00; bus.weight = 32'h1111_1111; bus.lock = 1'b0; bus.ready = 1'b0;

        // reset with all requesting, then first grant lands on index 0
        repeat (3) cyc(1'b0, 8'hff, 32'h1111_1111, 1'b0, 1'b1);
        cyc(1'b1, 8'h01, 32'h1111_1111, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 32'h1111_1111, 1'b0, 1'b1);

        // plain round robin 0,2,5,7,...
        repeat (10) cyc(1'b1, 8'ha5, 32'h1111_1111, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 32'h1111_1111, 1'b0, 1'b1);

        // weighted 3:1, then a zero weight behaving as 1
        repeat (10) cyc(1'b1, 8'h03, 32'h1111_1113, 1'b0, 1'b1);
        repeat (8)  cyc(1'b1, 8'h03, 32'h1111_1103, 1'b0, 1'b1);

        // backpressure on a weight-2 grant at index 2
        cyc(1'b0, 8'h00, 32'h1111_1211, 1'b0, 1'b0);
        cyc(1'b1, 8'h04, 32'h1111_1211, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 32'h1111_1211, 1'b1, 1'b0);
        cyc(1'b1, 8'hf8, 32'h1111_1511, 1'b0, 1'b0);
        cyc(1'b1, 8'h13, 32'h1111_1211, 1'b1, 1'b0);
        repeat (4) cyc(1'b1, 8'h0c, 32'h1111_1211, 1'b0, 1'b1);

        // lock holds index 0 without spending credit
        cyc(1'b0, 8'h00, 32'h1111_1111, 1'b0, 1'b1);
        cyc(1'b1, 8'h03, 32'h1111_1111, 1'b1, 1'b1);
        repeat (4) cyc(1'b1, 8'h03, 32'h1111_1111, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 8'h03, 32'h1111_1111, 1'b0, 1'b1);

        // drain to idle, then reset in the middle of a grant
        cyc(1'b1, 8'h00, 32'h1111_1111, 1'b0, 1'b1);
        cyc(1'b1, 8'h00, 32'h1111_1111, 1'b0, 1'b1);
        cyc(1'b1, 8'h10, 32'h1111_1111, 1'b0, 1'b0);
        cyc(1'b0, 8'hff, 32'h1111_1111, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 8'hff, 32'h1111_1111, 1'b0, 1'b1);

        // random traffic
        w = 32'h1111_1111;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) w = $urandom;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            cyc(($urandom_range(0, 199) != 0), r, w,
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
        end

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending predictions want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
